onehot_key_capture: RTL and testbench
=====================================

Name: onehot_key_capture

Overview:
- Upstream input stage for the 8-to-3 encoder.
- Synchronises and debounces 8 raw, asynchronous key lines, then qualifies a single stable press.
- Presents a registered one-hot vector `a` plus enable `en` that drive the encoder's `a`/`en` inputs directly.
- Rejects multi-key presses and flags them.

Parameters:
- WIDTH, 8: number of key lines; must match encoder input width.
- DEBOUNCE_CYCLES, 16: stable cycles required for press and for release; legal range 2..255.
- CNT_W, 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  WIDTH  raw key lines, active-high, asynchronous to clk, may bounce.
- a  output  WIDTH  registered one-hot key vector to encoder; all-zero when no valid press.
- en  output  1  registered encoder enable; 1 while a valid single-key press is held.
- press_pulse  output  1  one-cycle pulse on the cycle `a`/`en` first assert.
- multi_err  output  1  one-cycle pulse when a debounced press has popcount != 1.

Behaviour:
- Reset (rst_n=0, async assert, sync release):
  - sync1, sync2, sample and cnt clear to 0; FSM goes to IDLE.
  - a=0, en=0, press_pulse=0, multi_err=0.
- Synchroniser: two flops, key_in→sync1→sync2. FSM uses only sync2.
- IDLE:
  - sync2==0: stay.
  - sync2!=0: →DEBOUNCE, sample<=sync2, cnt<=0.
- DEBOUNCE:
  - sync2==0: →IDLE; outputs unchanged (still 0).
  - sync2!=0 and !=sample: sample<=sync2, cnt<=0 (restart).
  - sync2==sample and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - sync2==sample and cnt==DEBOUNCE_CYCLES-1: →HELD. Then:
    - if popcount(sample)==1: a<=sample, en<=1, press_pulse<=1 for one cycle.
    - else: a<=0, en<=0, multi_err<=1 for one cycle.
- HELD:
  - sync2==0: →RELEASE, cnt<=0.
  - sync2!=0: stay; a/en unchanged. A change to a different key does not update `a` (no rollover).
- RELEASE:
  - sync2!=0: →HELD, outputs unchanged (release bounce).
  - sync2==0 and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - sync2==0 and cnt==DEBOUNCE_CYCLES-1: →IDLE, a<=0, en<=0.
- Latency:
  - key_in changes before edge 1 and then stays stable.
  - a/en/press_pulse are high after edge DEBOUNCE_CYCLES+3.
  - Release: a/en clear after edge DEBOUNCE_CYCLES+3 counted from the first edge sampling all-zero.
- Pulses: press_pulse and multi_err are never high in the same cycle; each clears on the next edge.
- Invariant: en==1 iff a is one-hot; a!=0 only while en==1.
- Mid-operation reset: an async rst_n drop in any state forces all outputs to 0 immediately; after release, FSM restarts from IDLE.
- All counters saturate by FSM transition; cnt never wraps.

Test Plan:
- DEBOUNCE_CYCLES=4, reset then key_in=8'b0000_0100 held → a=8'b0000_0100, en=1, press_pulse=1 exactly after edge 7; press_pulse=0 after edge 8.
- Hold 8'b0000_0100, then key_in=0 held → a=0, en=0 exactly 7 edges after the first zero-sampling edge; no pulses.
- key_in toggles 8'b0001_0000/0 every 2 cycles for 20 cycles, then holds 8'b0001_0000 → no en during bouncing; en=1 exactly 7 edges after the last transition.
- key_in=8'b1000_0001 held → multi_err pulses once at edge 7; a=0, en=0 throughout; press_pulse never asserts.
- In HELD on 8'b0000_0010, key_in→8'b0010_0000 → a stays 8'b0000_0010. Then 2-cycle zero glitch and back → remains HELD, a unchanged.
- rst_n low for 1 cycle while en=1 → a=0, en=0 immediately (async). After release, a re-held key reasserts en exactly 7 edges later.

Source files
------------

// File: rtl/onehot_key_capture.sv
// Key input stage for the 8-to-3 encoder: two-flop synchroniser, press/release debounce,
// single-key qualification and multi-key rejection. Outputs are registered.
module onehot_key_capture #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] a,
    output logic             en,
    output logic             press_pulse,
    output logic             multi_err
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state, state_next;
    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] sample, sample_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] a_next;
    logic             en_next, press_next, multi_next;
    logic             sample_onehot;

    // Nonzero with a single bit set: clearing the lowest set bit leaves nothing.
    assign sample_onehot = (sample != '0) && ((sample & (sample - ONE)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sample      <= '0;
            cnt         <= '0;
            a           <= '0;
            en          <= 1'b0;
            press_pulse <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            state       <= state_next;
            sample      <= sample_next;
            cnt         <= cnt_next;
            a           <= a_next;
            en          <= en_next;
            press_pulse <= press_next;
            multi_err   <= multi_next;
        end
    end

    always_comb begin
        state_next  = state;
        sample_next = sample;
        cnt_next    = cnt;
        a_next      = a;
        en_next     = en;
        press_next  = 1'b0;
        multi_next  = 1'b0;
        case (state)
            IDLE: begin
                if (sync2 != '0) begin
                    state_next  = DEBOUNCE;
                    sample_next = sync2;
                    cnt_next    = '0;
                end
            end
            DEBOUNCE: begin
                if (sync2 == '0) begin
                    state_next = IDLE;
                end else if (sync2 != sample) begin
                    sample_next = sync2;
                    cnt_next    = '0;
                end else if (cnt != CNT_LAST) begin
                    cnt_next = cnt + 1'b1;
                end else begin
                    state_next = HELD;
                    if (sample_onehot) begin
                        a_next     = sample;
                        en_next    = 1'b1;
                        press_next = 1'b1;
                    end else begin
                        a_next     = '0;
                        en_next    = 1'b0;
                        multi_next = 1'b1;
                    end
                end
            end
            HELD: begin
                // No rollover: a different key while held leaves a untouched.
                if (sync2 == '0) begin
                    state_next = RELEASE;
                    cnt_next   = '0;
                end
            end
            RELEASE: begin
                if (sync2 != '0) begin
                    state_next = HELD;
                end else if (cnt != CNT_LAST) begin
                    cnt_next = cnt + 1'b1;
                end else begin
                    state_next = IDLE;
                    a_next     = '0;
                    en_next    = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_onehot_key_capture.sv
// Scoreboard bench for onehot_key_capture: a run-length reference model predicts
// press/multi/release events per edge; a negedge monitor pops and compares them.
module tb_onehot_key_capture;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key_in = '0;
    logic [7:0] a;
    logic       en, press_pulse, multi_err;

    onehot_key_capture #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .a(a), .en(en), .press_pulse(press_pulse), .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 1 press, 2 multi-key, 3 release
        logic [7:0] val;
        int         stamp;  // edge number the event becomes visible after
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    // Reference model: what the FSM sees is the key line two edges late; a press
    // qualifies after D+1 consecutive equal nonzero observations, a release after
    // D+1 consecutive zero observations while held.
    logic [7:0] k1 = '0, k2 = '0;
    logic       held = 1'b0;
    logic [7:0] run_val = '0;
    int         run_len = 0;
    int         zero_run = 0;
    logic [7:0] exp_a = '0;
    logic       exp_en = 1'b0;

    task automatic model_edge();
        logic [7:0] seen;
        if (!rst_n) begin
            k1 = '0; k2 = '0; held = 1'b0; run_val = '0; run_len = 0; zero_run = 0;
            exp_a = '0; exp_en = 1'b0;
            sb.delete();
            return;
        end
        seen = k2;
        k2 = k1;
        k1 = key_in;
        if (!held) begin
            if (seen == 8'h00) run_len = 0;
            else if (run_len > 0 && seen == run_val) run_len++;
            else begin
                run_val = seen;
                run_len = 1;
            end
            if (run_len == D + 1) begin
                held = 1'b1;
                run_len = 0;
                zero_run = 0;
                if ($countones(run_val) == 1) begin
                    exp_a = run_val;
                    exp_en = 1'b1;
                    sb.push_back('{1, run_val, cyc});
                end else begin
                    exp_a = '0;
                    exp_en = 1'b0;
                    sb.push_back('{2, 8'h00, cyc});
                end
            end
        end else begin
            if (seen == 8'h00) zero_run++;
            else zero_run = 0;
            if (zero_run == D + 1) begin
                held = 1'b0;
                zero_run = 0;
                if (exp_en) sb.push_back('{3, 8'h00, cyc});
                exp_a = '0;
                exp_en = 1'b0;
            end
        end
    endtask

    task automatic tick(input logic [7:0] kv);
        key_in = kv;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic hold(input logic [7:0] kv, input int n);
        for (int i = 0; i < n; i++) tick(kv);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        int  obs;
        ev_t e;
        if (!rst_n) begin
            prev_en = en;
        end else begin
            checks++;
            if (a !== exp_a || en !== exp_en) begin
                errors++;
                $display("FAIL outputs: a=%h en=%b expected a=%h en=%b (edge %0d)", a, en, exp_a, exp_en, cyc);
            end
            checks++;
            if (en !== ((a != 8'h00) && $onehot(a)) || (press_pulse && multi_err)) begin
                errors++;
                $display("FAIL invariant: a=%h en=%b press=%b multi=%b (edge %0d)", a, en, press_pulse, multi_err, cyc);
            end
            obs = press_pulse ? 1 : multi_err ? 2 : (prev_en && !en) ? 3 : 0;
            while (sb.size() > 0 && sb[0].stamp < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: kind %0d never seen, expected at edge %0d", e.kind, e.stamp);
            end
            if (sb.size() > 0 && sb[0].stamp == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs != e.kind || (e.kind == 1 && a !== e.val)) begin
                    errors++;
                    $display("FAIL event: got kind %0d a=%h expected kind %0d a=%h (edge %0d)", obs, a, e.kind, e.val, cyc);
                end
            end else begin
                checks++;
                if (obs != 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d expected none (edge %0d)", obs, cyc);
                end
            end
            prev_en = en;
        end
    end

    initial begin
        logic [7:0] kv;
        int         r;
        hold(8'h00, 3);
        check("reset_outputs", {a, en, press_pulse, multi_err}, 32'h0);
        rst_n = 1'b1;

        // Press latency: visible after edge D+3 counted from the first sampling edge
        hold(8'h04, D + 3);
        check("press_at_7", {a, en, press_pulse}, {8'h04, 1'b1, 1'b1});
        tick(8'h04);
        check("press_pulse_clear", {a, en, press_pulse}, {8'h04, 1'b1, 1'b0});
        hold(8'h04, 3);

        // Release latency
        hold(8'h00, D + 2);
        check("release_before", {a, en}, {8'h04, 1'b1});
        tick(8'h00);
        check("release_at_7", {a, en}, {8'h00, 1'b0});
        hold(8'h00, 4);

        // Bounce then stable
        for (int i = 0; i < 5; i++) begin
            hold(8'h10, 2);
            hold(8'h00, 2);
        end
        check("bounce_no_en", en, 1'b0);
        hold(8'h10, D + 2);
        check("bounce_before", en, 1'b0);
        tick(8'h10);
        check("bounce_settled", {a, en}, {8'h10, 1'b1});
        hold(8'h10, 2);
        hold(8'h00, 10);

        // Multi-key rejection
        hold(8'h81, D + 3);
        check("multi_err_at_7", {a, en, press_pulse, multi_err}, {8'h00, 1'b0, 1'b0, 1'b1});
        hold(8'h81, 4);
        check("multi_no_press", {a, en, multi_err}, {8'h00, 1'b0, 1'b0});
        hold(8'h00, 10);

        // No rollover, and release glitch while held
        hold(8'h02, 10);
        hold(8'h20, 5);
        check("no_rollover", {a, en}, {8'h02, 1'b1});
        hold(8'h00, 2);
        hold(8'h20, 5);
        check("glitch_held", {a, en}, {8'h02, 1'b1});

        // Async reset while held
        rst_n = 1'b0;
        #1;
        check("async_reset", {a, en}, {8'h00, 1'b0});
        tick(8'h20);
        rst_n = 1'b1;
        hold(8'h20, D + 2);
        check("post_reset_before", en, 1'b0);
        tick(8'h20);
        check("post_reset_press", {a, en, press_pulse}, {8'h20, 1'b1, 1'b1});
        hold(8'h00, 10);

        // Randomised bursts
        for (int b = 0; b < 80; b++) begin
            r = $urandom_range(0, 3);
            if (r == 0) kv = 8'h00;
            else if (r == 3) kv = 8'($urandom);
            else kv = 8'h01 << $urandom_range(0, 7);
            hold(kv, $urandom_range(1, 12));
        end
        hold(8'h00, 20);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
